// File: rtl/axi4l_lbus_bridge.sv
// AXI4-Lite slave to lbus master, one access at a time; req one cycle after AXI handshake, response one cycle after ack, held until accepted.
// Define AXI4L_LBUS_WSTRB_RMW_EN to turn partial-strobe writes into lbus read-modify-write.
module axi4l_lbus_bridge #(
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC,
  parameter bit          WR_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        lbus_m_req,
  output logic [29:0] lbus_m_addr,
  output logic        lbus_m_rw,
  output logic [31:0] lbus_m_wdata,
  input  logic [31:0] lbus_m_rdata,
  input  logic        lbus_m_ack,
  input  logic        lbus_m_err
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, RD_REQ, B_RESP, R_RESP
`ifdef AXI4L_LBUS_WSTRB_RMW_EN
    , RMW_RD, RMW_WR
`endif
  } state_t;

  state_t      state_q;
  logic        prio_q, req_q, rw_q, bvalid_q, rvalid_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        wr_elig, tie, grant_wr, grant_rd, idle;
  logic [1:0]  ack_resp;
  logic        unused_addr_lsb;

  assign wr_elig  = s_axi_awvalid & s_axi_wvalid;
  assign tie      = wr_elig & s_axi_arvalid;
  assign grant_wr = wr_elig & (~s_axi_arvalid | prio_q);
  assign grant_rd = s_axi_arvalid & (~wr_elig | ~prio_q);
  assign idle     = (state_q == IDLE);
  assign ack_resp = lbus_m_err ? 2'b10 : 2'b00;

  // AW and W are only ever taken together.
  assign s_axi_awready = idle & grant_wr;
  assign s_axi_wready  = idle & grant_wr;
  assign s_axi_arready = idle & grant_rd;

  assign s_axi_bresp  = bresp_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign lbus_m_req   = req_q;
  assign lbus_m_addr  = addr_q;
  assign lbus_m_rw    = rw_q;
  assign lbus_m_wdata = wdata_q;

  assign unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifdef AXI4L_LBUS_WSTRB_RMW_EN
  logic [31:0] wbuf_q, merged;
  logic [3:0]  strb_q;
  always_comb begin
    merged = lbus_m_rdata;
    for (int i = 0; i < 4; i++)
      if (strb_q[i]) merged[8*i +: 8] = wbuf_q[8*i +: 8];
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^s_axi_wstrb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= WR_FIRST;
      req_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
`ifdef AXI4L_LBUS_WSTRB_RMW_EN
      wbuf_q   <= '0;
      strb_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (tie) prio_q <= ~prio_q;
          if (grant_wr) begin
            addr_q <= s_axi_awaddr[31:2] & ADDR_MASK[31:2];
`ifdef AXI4L_LBUS_WSTRB_RMW_EN
            wbuf_q <= s_axi_wdata;
            strb_q <= s_axi_wstrb;
            if (s_axi_wstrb == 4'h0) begin
              bvalid_q <= 1'b1;
              bresp_q  <= 2'b00;
              state_q  <= B_RESP;
            end else if (s_axi_wstrb != 4'hF) begin
              req_q   <= 1'b1;
              rw_q    <= 1'b0;
              state_q <= RMW_RD;
            end else begin
              req_q   <= 1'b1;
              rw_q    <= 1'b1;
              wdata_q <= s_axi_wdata;
              state_q <= WR_REQ;
            end
`else
            req_q   <= 1'b1;
            rw_q    <= 1'b1;
            wdata_q <= s_axi_wdata;
            state_q <= WR_REQ;
`endif
          end else if (grant_rd) begin
            addr_q  <= s_axi_araddr[31:2] & ADDR_MASK[31:2];
            req_q   <= 1'b1;
            rw_q    <= 1'b0;
            state_q <= RD_REQ;
          end
        end
        WR_REQ: if (lbus_m_ack) begin
          req_q    <= 1'b0;
          bvalid_q <= 1'b1;
          bresp_q  <= ack_resp;
          state_q  <= B_RESP;
        end
        RD_REQ: if (lbus_m_ack) begin
          req_q    <= 1'b0;
          rvalid_q <= 1'b1;
          rresp_q  <= ack_resp;
          rdata_q  <= lbus_m_rdata;
          state_q  <= R_RESP;
        end
        B_RESP: if (s_axi_bready) begin
          bvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
        R_RESP: if (s_axi_rready) begin
          rvalid_q <= 1'b0;
          state_q  <= IDLE;
        end
`ifdef AXI4L_LBUS_WSTRB_RMW_EN
        RMW_RD: if (lbus_m_ack) begin
          req_q <= 1'b0;
          if (lbus_m_err) begin
            bvalid_q <= 1'b1;
            bresp_q  <= 2'b10;
            state_q  <= B_RESP;
          end else begin
            wdata_q <= merged;
            rw_q    <= 1'b1;
            state_q <= RMW_WR;
          end
        end
        // First cycle here keeps req low so the write never follows the read ack back-to-back.
        RMW_WR: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (lbus_m_ack) begin
            req_q    <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= ack_resp;
            state_q  <= B_RESP;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
